// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: memory freeze, taken-branch flush, load-use stall,
// plus a saturating count of cycles in which any pipeline register was held or bubbled.
module pipeline_hazard_ctrl #(
    parameter int REG_W        = 5,
    parameter int ZERO_REG     = 31,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             clr_cnt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_count
);

    localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [REG_W-1:0] ZERO_SPEC = REG_W'(ZERO_REG);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_MEM_WAIT, S_FLUSH} state_t;

    state_t            r_state, w_state_next;
    logic              r_pending_br, w_pending_br_next;
    logic [FL_W-1:0]   r_flush_left, w_flush_left_next;
    logic [CNT_W-1:0]  r_stall_count;
    logic              w_load_use;
    logic              w_freeze;
    logic              w_stall;

    assign w_load_use = ex_is_load && (ex_rd != ZERO_SPEC) &&
                        ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));

    always_comb begin
        pc_en             = 1'b1;
        ifid_en           = 1'b1;
        idex_en           = 1'b1;
        exmem_en          = 1'b1;
        memwb_en          = 1'b1;
        ifid_flush        = 1'b0;
        idex_flush        = 1'b0;
        w_freeze          = 1'b0;
        w_state_next      = r_state;
        w_pending_br_next = r_pending_br;
        w_flush_left_next = r_flush_left;

        case (r_state)
            S_INIT: begin
                ifid_flush   = 1'b1;
                idex_flush   = 1'b1;
                w_state_next = S_RUN;
            end
            S_FLUSH: begin
                // EX holds a bubble here, so branch_taken cannot be genuine and is ignored.
                if (mem_busy) begin
                    w_freeze = 1'b1;
                end else begin
                    ifid_flush        = 1'b1;
                    w_flush_left_next = r_flush_left - FL_W'(1);
                    if (r_flush_left == FL_W'(1)) begin
                        w_state_next = S_RUN;
                    end
                end
            end
            default: begin
                if (mem_busy) begin
                    w_freeze          = 1'b1;
                    w_pending_br_next = ((r_state == S_MEM_WAIT) && r_pending_br) || branch_taken;
                    w_state_next      = S_MEM_WAIT;
                end else if (((r_state == S_MEM_WAIT) && r_pending_br) || branch_taken) begin
                    ifid_flush        = 1'b1;
                    idex_flush        = 1'b1;
                    w_pending_br_next = 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        w_flush_left_next = FL_W'(FLUSH_CYCLES - 1);
                        w_state_next      = S_FLUSH;
                    end else begin
                        w_state_next = S_RUN;
                    end
                end else begin
                    w_pending_br_next = 1'b0;
                    w_state_next      = S_RUN;
                    if (w_load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
            end
        endcase

        // A freeze holds every register and never bubbles anything.
        if (w_freeze) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end
    end

    assign w_stall = !(pc_en && ifid_en && idex_en && exmem_en && memwb_en) || ifid_flush || idex_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_INIT;
            r_pending_br  <= 1'b0;
            r_flush_left  <= '0;
            r_stall_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_pending_br <= w_pending_br_next;
            r_flush_left <= w_flush_left_next;
            if (clr_cnt) begin
                r_stall_count <= '0;
            end else if (w_stall && (r_state != S_INIT) && !(&r_stall_count)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (FLUSH_CYCLES=1/CNT_W=16 and FLUSH_CYCLES=3/CNT_W=4)
// driven in parallel, checked against directed tables and a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rn, id_rm, ex_rd;
    logic       id_uses_rn, id_uses_rm, ex_is_load, branch_taken, mem_busy, clr_cnt;

    logic a_pc_en, a_ifid_en, a_idex_en, a_exmem_en, a_memwb_en, a_ifid_flush, a_idex_flush;
    logic b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_memwb_en, b_ifid_flush, b_idex_flush;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;
    logic [6:0]  a_out, b_out;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       ld;
        logic [4:0] rd;
        logic [4:0] rn;
        logic       urn;
        logic [4:0] rm;
        logic       urm;
        logic       br;
        logic       mb;
        logic       clr;
    } stim_t;

    // Reference model: per instance, INIT flag, deferred branch, remaining flush-only cycles, count.
    bit         m_init[2];
    bit         m_pend[2];
    int         m_fl[2];
    int         m_cnt[2];
    int         fc[2]   = '{1, 3};
    int         cmax[2] = '{65535, 15};
    logic [6:0] exp_out[2];
    int         exp_cnt[2];

    localparam logic [6:0] O_INIT = 7'b1111111;
    localparam logic [6:0] O_BOTH = 7'b1111111;
    localparam logic [6:0] O_FRZ  = 7'b0000000;
    localparam logic [6:0] O_LU   = 7'b0011101;
    localparam logic [6:0] O_IFF  = 7'b1111110;
    localparam logic [6:0] O_RUN  = 7'b1111100;

    assign a_out = {a_pc_en, a_ifid_en, a_idex_en, a_exmem_en, a_memwb_en, a_ifid_flush, a_idex_flush};
    assign b_out = {b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_memwb_en, b_ifid_flush, b_idex_flush};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn),
        .id_uses_rm(id_uses_rm), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .clr_cnt(clr_cnt), .pc_en(a_pc_en), .ifid_en(a_ifid_en),
        .idex_en(a_idex_en), .exmem_en(a_exmem_en), .memwb_en(a_memwb_en),
        .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush), .stall_count(a_cnt)
    );

    pipeline_hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn),
        .id_uses_rm(id_uses_rm), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .clr_cnt(clr_cnt), .pc_en(b_pc_en), .ifid_en(b_ifid_en),
        .idex_en(b_idex_en), .exmem_en(b_exmem_en), .memwb_en(b_memwb_en),
        .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush), .stall_count(b_cnt)
    );

    function automatic stim_t mk(int ld, int rd, int rn, int urn, int rm, int urm, int br, int mb, int clr);
        stim_t s;
        s.ld  = 1'(ld);
        s.rd  = 5'(rd);
        s.rn  = 5'(rn);
        s.urn = 1'(urn);
        s.rm  = 5'(rm);
        s.urm = 1'(urm);
        s.br  = 1'(br);
        s.mb  = 1'(mb);
        s.clr = 1'(clr);
        return s;
    endfunction

    task automatic drive(input stim_t s);
        ex_is_load   = s.ld;
        ex_rd        = s.rd;
        id_rn        = s.rn;
        id_uses_rn   = s.urn;
        id_rm        = s.rm;
        id_uses_rm   = s.urm;
        branch_taken = s.br;
        mem_busy     = s.mb;
        clr_cnt      = s.clr;
    endtask

    function automatic bit hazard_load_use();
        return ex_is_load && (ex_rd != 5'd31) &&
               ((id_uses_rn && id_rn == ex_rd) || (id_uses_rm && id_rm == ex_rd));
    endfunction

    function automatic logic [6:0] model_out(input int k);
        if (!reset || m_init[k])          return O_INIT;
        if (mem_busy)                     return O_FRZ;
        if (m_fl[k] > 0)                  return O_IFF;
        if (m_pend[k] || branch_taken)    return O_BOTH;
        if (hazard_load_use())            return O_LU;
        return O_RUN;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_init[k] = 1'b1;
            m_pend[k] = 1'b0;
            m_fl[k]   = 0;
            m_cnt[k]  = 0;
        end
    endtask

    task automatic settle();
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_out[k] = model_out(k);
            exp_cnt[k] = reset ? m_cnt[k] : 0;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                if (clr_cnt)
                    m_cnt[k] = 0;
                else if (!m_init[k] && exp_out[k] != O_RUN && m_cnt[k] < cmax[k])
                    m_cnt[k]++;
                if (m_init[k]) begin
                    m_init[k] = 1'b0;
                end else if (m_fl[k] > 0) begin
                    if (!mem_busy) m_fl[k]--;
                end else if (mem_busy) begin
                    m_pend[k] = m_pend[k] | branch_taken;
                end else if (m_pend[k] || branch_taken) begin
                    m_pend[k] = 1'b0;
                    m_fl[k]   = fc[k] - 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        drive(mk(1, 3, 3, 1, 0, 0, 1, 1, 0));
        settle();
        checks++;
        if (a_out !== O_INIT || b_out !== O_INIT || a_cnt !== 16'd0 || b_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: a=%b b=%b cnt=%0d/%0d expected %b cnt=0", a_out, b_out, a_cnt, b_cnt, O_INIT);
        end
        advance();
        advance();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        settle();
        checks++;
        if (a_out !== O_INIT || b_out !== O_INIT) begin
            errors++;
            $display("FAIL init_cycle: a=%b b=%b expected %b", a_out, b_out, O_INIT);
        end
        advance();
        settle();
        checks++;
        if (a_out !== O_RUN || b_out !== O_RUN || a_cnt !== 16'd0 || b_cnt !== 4'd0) begin
            errors++;
            $display("FAIL run_after_init: a=%b b=%b cnt=%0d/%0d expected %b cnt=0", a_out, b_out, a_cnt, b_cnt, O_RUN);
        end
        advance();
    endtask

    task automatic test_load_use();
        stim_t      s[6];
        logic [6:0] e[6];
        s = '{mk(1, 3, 3, 1, 0, 0, 0, 0, 0), mk(0, 3, 3, 1, 0, 0, 0, 0, 0),
              mk(1, 31, 31, 1, 31, 1, 0, 0, 0), mk(1, 7, 0, 0, 7, 1, 0, 0, 0),
              mk(1, 7, 7, 0, 2, 1, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        e = '{O_LU, O_RUN, O_RUN, O_LU, O_RUN, O_RUN};
        for (int c = 0; c < 6; c++) begin
            drive(s[c]);
            settle();
            checks++;
            if (a_out !== e[c] || b_out !== e[c]) begin
                errors++;
                $display("FAIL load_use[%0d]: a=%b b=%b expected %b", c, a_out, b_out, e[c]);
            end
            checks++;
            if (a_cnt !== 16'(exp_cnt[0]) || b_cnt !== 4'(exp_cnt[1])) begin
                errors++;
                $display("FAIL load_use_cnt[%0d]: cnt=%0d/%0d expected %0d/%0d", c, a_cnt, b_cnt, exp_cnt[0], exp_cnt[1]);
            end
            advance();
        end
    endtask

    task automatic test_branch();
        stim_t      s[4];
        logic [6:0] ea[4];
        logic [6:0] eb[4];
        s  = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        ea = '{O_BOTH, O_RUN, O_RUN, O_RUN};
        eb = '{O_BOTH, O_IFF, O_IFF, O_RUN};
        for (int c = 0; c < 4; c++) begin
            drive(s[c]);
            settle();
            checks++;
            if (a_out !== ea[c] || b_out !== eb[c]) begin
                errors++;
                $display("FAIL branch[%0d]: a=%b b=%b expected a=%b b=%b", c, a_out, b_out, ea[c], eb[c]);
            end
            checks++;
            if (a_cnt !== 16'(exp_cnt[0]) || b_cnt !== 4'(exp_cnt[1])) begin
                errors++;
                $display("FAIL branch_cnt[%0d]: cnt=%0d/%0d expected %0d/%0d", c, a_cnt, b_cnt, exp_cnt[0], exp_cnt[1]);
            end
            advance();
        end
    endtask

    task automatic test_mem_busy();
        stim_t      s[9];
        logic [6:0] ea[9];
        logic [6:0] eb[9];
        s  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0), mk(0, 0, 0, 0, 0, 0, 1, 1, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 1, 0), mk(0, 0, 0, 0, 0, 0, 0, 1, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 1, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        ea = '{O_FRZ, O_FRZ, O_FRZ, O_FRZ, O_BOTH, O_FRZ, O_RUN, O_RUN, O_RUN};
        eb = '{O_FRZ, O_FRZ, O_FRZ, O_FRZ, O_BOTH, O_FRZ, O_IFF, O_IFF, O_RUN};
        for (int c = 0; c < 9; c++) begin
            drive(s[c]);
            settle();
            checks++;
            if (a_out !== ea[c] || b_out !== eb[c]) begin
                errors++;
                $display("FAIL mem_busy[%0d]: a=%b b=%b expected a=%b b=%b", c, a_out, b_out, ea[c], eb[c]);
            end
            checks++;
            if (a_cnt !== 16'(exp_cnt[0]) || b_cnt !== 4'(exp_cnt[1])) begin
                errors++;
                $display("FAIL mem_busy_cnt[%0d]: cnt=%0d/%0d expected %0d/%0d", c, a_cnt, b_cnt, exp_cnt[0], exp_cnt[1]);
            end
            advance();
        end
    endtask

    task automatic test_simultaneous();
        stim_t      s[5];
        logic [6:0] ea[5];
        logic [6:0] eb[5];
        s  = '{mk(1, 3, 3, 1, 0, 0, 1, 1, 0), mk(1, 3, 3, 1, 0, 0, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 1, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        ea = '{O_FRZ, O_BOTH, O_RUN, O_BOTH, O_RUN};
        eb = '{O_FRZ, O_BOTH, O_IFF, O_IFF, O_RUN};
        for (int c = 0; c < 5; c++) begin
            drive(s[c]);
            settle();
            checks++;
            if (a_out !== ea[c] || b_out !== eb[c]) begin
                errors++;
                $display("FAIL simultaneous[%0d]: a=%b b=%b expected a=%b b=%b", c, a_out, b_out, ea[c], eb[c]);
            end
            advance();
        end
    endtask

    task automatic test_counter();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        settle();
        advance();
        for (int c = 0; c < 20; c++) begin
            drive(mk(1, 5, 5, 1, 0, 0, 0, 0, 0));
            settle();
            checks++;
            if (a_cnt !== 16'(exp_cnt[0]) || b_cnt !== 4'(exp_cnt[1])) begin
                errors++;
                $display("FAIL count_ramp[%0d]: cnt=%0d/%0d expected %0d/%0d", c, a_cnt, b_cnt, exp_cnt[0], exp_cnt[1]);
            end
            advance();
        end
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        settle();
        checks++;
        if (a_cnt !== 16'd20 || b_cnt !== 4'd15) begin
            errors++;
            $display("FAIL count_saturate: cnt=%0d/%0d expected 20/15", a_cnt, b_cnt);
        end
        drive(mk(1, 5, 5, 1, 0, 0, 0, 0, 1));
        settle();
        advance();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        settle();
        checks++;
        if (a_cnt !== 16'd0 || b_cnt !== 4'd0) begin
            errors++;
            $display("FAIL count_clear: cnt=%0d/%0d expected 0/0", a_cnt, b_cnt);
        end
        advance();
    endtask

    task automatic test_reset_mid_flush();
        drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        settle();
        advance();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        settle();
        checks++;
        if (b_out !== O_IFF || b_cnt !== 4'd1) begin
            errors++;
            $display("FAIL in_flush: b=%b cnt=%0d expected %b cnt=1", b_out, b_cnt, O_IFF);
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (a_out !== O_INIT || b_out !== O_INIT || a_cnt !== 16'd0 || b_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_flush: a=%b b=%b cnt=%0d/%0d expected %b cnt=0", a_out, b_out, a_cnt, b_cnt, O_INIT);
        end
        settle();
        advance();
        reset = 1'b1;
        settle();
        advance();
        settle();
        checks++;
        if (a_out !== O_RUN || b_out !== O_RUN || a_cnt !== 16'd0 || b_cnt !== 4'd0) begin
            errors++;
            $display("FAIL run_after_rereset: a=%b b=%b cnt=%0d/%0d expected %b cnt=0", a_out, b_out, a_cnt, b_cnt, O_RUN);
        end
        advance();
    endtask

    function automatic int rreg();
        int v = int'($urandom_range(0, 4));
        return (v == 4) ? 31 : v;
    endfunction

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(mk(int'($urandom_range(0, 1)), rreg(), rreg(), int'($urandom_range(0, 1)), rreg(),
                     int'($urandom_range(0, 1)), int'($urandom_range(0, 5) == 0),
                     int'($urandom_range(0, 4) == 0), int'($urandom_range(0, 29) == 0)));
            settle();
            checks++;
            if (a_out !== exp_out[0] || a_cnt !== 16'(exp_cnt[0])) begin
                errors++;
                $display("FAIL random_a[%0d]: out=%b cnt=%0d expected out=%b cnt=%0d", c, a_out, a_cnt, exp_out[0], exp_cnt[0]);
            end
            checks++;
            if (b_out !== exp_out[1] || b_cnt !== 4'(exp_cnt[1])) begin
                errors++;
                $display("FAIL random_b[%0d]: out=%b cnt=%0d expected out=%b cnt=%0d", c, b_out, b_cnt, exp_out[1], exp_cnt[1]);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_busy();
        test_simultaneous();
        test_counter();
        test_reset_mid_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
